garage_door_ctrl: RTL and testbench

Parametrised second-generation garage door controller. It drives the up and down motor enables from the limit switches and a push-button Activate input. Over the first-generation controller it adds:
- pause and reverse on Activate mid-travel
- obstacle auto-reverse while closing
- motor dead-time before any direction change
- travel-timeout fault
- optional auto-close from the open position

Sits between the debounced switch/sensor inputs and the motor driver.

---
 rtl/gdc_pkg.sv | 22 ++
 rtl/gdc_timer.sv | 22 ++
 rtl/garage_door_ctrl.sv | 135 +++++++++++++
 tb/tb_garage_door_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gdc_pkg.sv
// Shared types and constants for the garage door controller.
package gdc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MV_DN = 3'd1,
    MV_UP = 3'd2,
    PAUSE = 3'd3,
    DEAD  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gdc_timer.sv
// Shared cycle counter: synchronous clear, count enable, saturates at all-ones.
module gdc_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != {CW{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/garage_door_ctrl.sv
// Garage door controller: pause/reverse, obstacle auto-reverse, motor dead-time,
// travel timeout fault and optional auto-close, with Moore motor outputs.
module garage_door_ctrl
  import gdc_pkg::*;
#(
  parameter int MOVE_TIMEOUT = 1000,
  parameter int AUTO_CLOSE   = 0,
  parameter int DEAD_CYCLES  = 4,
  parameter int CW           = $clog2(max3(MOVE_TIMEOUT, AUTO_CLOSE, DEAD_CYCLES) + 1)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       Activate,
  input  logic       Obstacle,
  input  logic       Fault_Clr,
  output logic       UP_M,
  output logic       DN_M,
  output logic       Fault,
  output logic [2:0] State
);

  localparam logic          AC_EN     = (AUTO_CLOSE > 0);
  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_TIMEOUT - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] AC_LAST   = CW'((AUTO_CLOSE > 0) ? AUTO_CLOSE - 1 : 0);

  state_t        state, state_next;
  logic          last_dir, last_dir_next;
  logic          target, target_next;
  logic          activate_q;
  logic          act;
  logic          auto_cond;
  logic          timer_clr, timer_en;
  logic [CW-1:0] timer;

  assign act       = Activate & ~activate_q;
  assign auto_cond = AC_EN & UP_Max & ~DN_Max & ~Obstacle;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      last_dir   <= DIR_UP;
      target     <= DIR_UP;
      activate_q <= 1'b0;
    end else begin
      state      <= state_next;
      last_dir   <= last_dir_next;
      target     <= target_next;
      activate_q <= Activate;
    end
  end

  // Within each state the branches follow event priority: limits, obstacle, act, timeout.
  always_comb begin
    state_next    = state;
    last_dir_next = last_dir;
    target_next   = target;
    case (state)
      IDLE: begin
        if (UP_Max && DN_Max)                 state_next = FAULT;
        else if (act)                         state_next = UP_Max ? MV_DN : MV_UP;
        else if (auto_cond && timer == AC_LAST) state_next = MV_DN;
      end
      MV_UP: begin
        if (UP_Max && DN_Max)       state_next = FAULT;
        else if (UP_Max)            state_next = IDLE;
        else if (act) begin
          state_next    = PAUSE;
          last_dir_next = DIR_UP;
        end
        else if (timer == MOVE_LAST) state_next = FAULT;
      end
      MV_DN: begin
        if (UP_Max && DN_Max)       state_next = FAULT;
        else if (DN_Max)            state_next = IDLE;
        else if (Obstacle) begin
          state_next  = DEAD;
          target_next = DIR_UP;
        end
        else if (act) begin
          state_next    = PAUSE;
          last_dir_next = DIR_DN;
        end
        else if (timer == MOVE_LAST) state_next = FAULT;
      end
      PAUSE: begin
        if (act) begin
          state_next  = DEAD;
          target_next = ~last_dir;
        end
      end
      DEAD: begin
        if (timer == DEAD_LAST) begin
          if (target == DIR_UP) begin
            state_next = MV_UP;
          end else if (Obstacle) begin
            state_next    = PAUSE;
            last_dir_next = DIR_UP;
          end else begin
            state_next = MV_DN;
          end
        end
      end
      FAULT: begin
        if (Fault_Clr) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Obstacle in IDLE restarts the auto-close count.
  assign timer_clr = (state_next != state) || ((state == IDLE) && Obstacle);
  assign timer_en  = (state == MV_UP) || (state == MV_DN) || (state == DEAD) ||
                     ((state == IDLE) && auto_cond);

  gdc_timer #(
    .CW(CW)
  ) u_timer (
    .clk   (CLK),
    .rst_n (RST),
    .clear (timer_clr),
    .enable(timer_en),
    .count (timer)
  );

  always_comb begin
    UP_M  = (state == MV_UP);
    DN_M  = (state == MV_DN);
    Fault = (state == FAULT);
    State = state;
  end

endmodule

// File: tb/tb_garage_door_ctrl.sv
// Scoreboard bench: driver feeds a behavioural door model and queues expected
// outputs; a monitor compares them against the DUT every cycle.
module tb_garage_door_ctrl;

  localparam int TO = 20;
  localparam int AC = 10;
  localparam int DC = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic       UP_Max, DN_Max, Activate, Obstacle, Fault_Clr;
  logic       UP_M, DN_M, Fault;
  logic [2:0] State;

  garage_door_ctrl #(
    .MOVE_TIMEOUT(TO),
    .AUTO_CLOSE  (AC),
    .DEAD_CYCLES (DC)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .UP_Max   (UP_Max),
    .DN_Max   (DN_Max),
    .Activate (Activate),
    .Obstacle (Obstacle),
    .Fault_Clr(Fault_Clr),
    .UP_M     (UP_M),
    .DN_M     (DN_M),
    .Fault    (Fault),
    .State    (State)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  logic r_up, r_dn, r_act, r_obs, r_clr;

  // Behavioural door model: direction of travel, countdowns and flags.
  int m_motion;     // +1 opening, -1 closing, 0 stopped
  int m_dead;       // remaining dead-time cycles, 0 when not in dead time
  int m_dead_to;    // direction to take after dead time
  bit m_paused;
  int m_pause_prev; // direction that was interrupted by the pause
  bit m_fault;
  int m_travel;
  int m_idle;
  bit m_prev_act;

  task automatic model_reset();
    m_motion = 0; m_dead = 0; m_dead_to = 0; m_paused = 0; m_pause_prev = 1;
    m_fault = 0; m_travel = 0; m_idle = 0; m_prev_act = 0;
  endtask

  task automatic model_step(input bit up, input bit dn, input bit a, input bit obs,
                            input bit clr, input bit rstn);
    bit ev;
    bit reached;
    if (!rstn) begin
      model_reset();
      return;
    end
    ev = a && !m_prev_act;
    m_prev_act = a;
    if (m_fault) begin
      if (clr) begin m_fault = 0; m_idle = 0; end
    end else if (m_dead > 0) begin
      m_dead--;
      if (m_dead == 0) begin
        if (m_dead_to > 0) begin m_motion = 1; m_travel = 0; end
        else if (obs)      begin m_paused = 1; m_pause_prev = 1; end
        else               begin m_motion = -1; m_travel = 0; end
      end
    end else if (m_paused) begin
      if (ev) begin m_paused = 0; m_dead = DC; m_dead_to = -m_pause_prev; end
    end else if (m_motion != 0) begin
      reached = (m_motion > 0) ? up : dn;
      if (up && dn)                  begin m_motion = 0; m_fault = 1; end
      else if (reached)              begin m_motion = 0; m_idle = 0; end
      else if (m_motion < 0 && obs)  begin m_motion = 0; m_dead = DC; m_dead_to = 1; end
      else if (ev)                   begin m_paused = 1; m_pause_prev = m_motion; m_motion = 0; end
      else begin
        m_travel++;
        if (m_travel >= TO) begin m_motion = 0; m_fault = 1; end
      end
    end else begin
      if (up && dn)  m_fault = 1;
      else if (ev)   begin m_motion = up ? -1 : 1; m_travel = 0; end
      else if (obs)  m_idle = 0;
      else if (up && !dn) begin
        m_idle++;
        if (m_idle >= AC) begin m_motion = -1; m_travel = 0; m_idle = 0; end
      end
    end
  endtask

  function automatic logic [2:0] model_code();
    if (m_fault)         return 3'd5;
    if (m_dead > 0)      return 3'd4;
    if (m_paused)        return 3'd3;
    if (m_motion > 0)    return 3'd2;
    if (m_motion < 0)    return 3'd1;
    return 3'd0;
  endfunction

  task automatic cyc();
    logic [2:0] c;
    UP_Max = r_up; DN_Max = r_dn; Activate = r_act; Obstacle = r_obs; Fault_Clr = r_clr;
    @(posedge CLK);
    model_step(r_up, r_dn, r_act, r_obs, r_clr, RST);
    c = model_code();
    exp_q.push_back({c == 3'd2, c == 3'd1, c == 3'd5, c});
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) cyc();
  endtask

  task automatic async_reset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    total++;
    if (UP_M !== 1'b0 || DN_M !== 1'b0 || Fault !== 1'b0 || State !== 3'd0) begin
      bad++;
      $display("FAIL async_reset got={%b,%b,%b,%0d} exp={0,0,0,0}", UP_M, DN_M, Fault, State);
    end
  endtask

  // Monitor
  logic prev_up = 1'b0, prev_dn = 1'b0;
  initial begin
    logic [5:0] e, g;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {UP_M, DN_M, Fault, State};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs t=%0t got up=%b dn=%b flt=%b st=%0d exp up=%b dn=%b flt=%b st=%0d",
                   $time, g[5], g[4], g[3], g[2:0], e[5], e[4], e[3], e[2:0]);
        end
      end
      total++;
      if ((UP_M && DN_M) || (UP_M && prev_dn) || (DN_M && prev_up)) begin
        bad++;
        $display("FAIL motor_overlap t=%0t got up=%b dn=%b prev_up=%b prev_dn=%b exp no overlap",
                 $time, UP_M, DN_M, prev_up, prev_dn);
      end
      prev_up = UP_M;
      prev_dn = DN_M;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0;
    r_up = 0; r_dn = 0; r_act = 0; r_obs = 0; r_clr = 0;
    model_reset();
    tick(3);
    RST = 1'b1;
    tick(1);

    // Basic close
    r_up = 1; r_act = 1; tick(1); r_act = 0; tick(7);
    r_up = 0; r_dn = 1; tick(3);

    // Obstacle reverse while closing
    r_dn = 0; r_up = 1; r_act = 1; tick(1); r_act = 0; r_up = 0; tick(4);
    r_obs = 1; tick(1); r_obs = 0; tick(6);
    r_up = 1; tick(2);

    // Pause and resume, Activate held high
    r_up = 0; r_dn = 1; r_act = 1; tick(1); r_act = 0; r_dn = 0; tick(3);
    r_act = 1; tick(1); r_act = 0;
    for (int i = 0; i < 50; i++) begin r_obs = 1'($urandom_range(0, 1)); tick(1); end
    r_obs = 0; r_act = 1; tick(5); r_act = 0; tick(3);
    r_dn = 1; tick(2);

    // Travel timeout, then fault clear
    r_act = 1; tick(1); r_act = 0; r_dn = 0; tick(24);
    r_act = 1; tick(1); r_act = 0; tick(1); r_act = 1; tick(1); r_act = 0;
    r_clr = 1; tick(1); r_clr = 0; tick(2);

    // Auto-close with an obstacle restart
    r_up = 1; tick(6); r_obs = 1; tick(1); r_obs = 0; tick(12);
    r_up = 0; r_dn = 1; tick(2);

    // Both limits, then async reset mid-motion
    r_up = 1; r_dn = 1; tick(2);
    r_up = 0; r_dn = 0; r_clr = 1; tick(1); r_clr = 0;
    r_up = 1; r_act = 1; tick(1); r_act = 0; r_up = 0; tick(3);
    async_reset();
    tick(2);
    RST = 1'b1;
    r_act = 1; tick(1); r_act = 0; tick(3);
    r_up = 1; tick(1);

    // Randomized operation
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) r_up = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) r_dn = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 5) == 0) r_act = ~r_act;
      r_obs = ($urandom_range(0, 15) == 0);
      r_clr = ($urandom_range(0, 7) == 0);
      tick(1);
    end

    repeat (3) @(negedge CLK);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
